// File: rtl/fas_pkg.sv
// Shared types and sizes for the FAS pipeline: the FFT frame format and the
// analysis-stage state encoding.
package fas_pkg;

  localparam int DW    = 16;
  localparam int NBINS = 16;
  localparam int IDX_W = 4;
  localparam int MAG_W = 33;

  typedef enum logic {
    IDLE,
    SCAN
  } ana_state_t;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude of one complex bin: re*re + im*im, kept at
// full 33-bit precision so the -1-1j corner (2^31) is representable.
module fas_mag_sq
  import fas_pkg::*;
(
  input  cplx_t              sample,
  output logic [MAG_W-1:0]   mag
);

  logic signed [DW-1:0]   re;
  logic signed [DW-1:0]   im;
  logic signed [2*DW-1:0] re_sq;
  logic signed [2*DW-1:0] im_sq;

  assign re    = sample.re;
  assign im    = sample.im;
  assign re_sq = re * re;
  assign im_sq = im * im;

  // Both squares are non-negative, so zero-extending into the carry bit is exact.
  assign mag = {1'b0, re_sq} + {1'b0, im_sq};

endmodule

// File: rtl/fas_freq_analyzer.sv
// Peak-bin finder: captures a 16-bin FFT frame and scans it one bin per cycle,
// reporting the index of the largest |X|^2 with a one-cycle done pulse.
module fas_freq_analyzer
  import fas_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq,
  output logic        overrun
);

  ana_state_t       state;
  ana_state_t       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] max_idx;
  logic [MAG_W-1:0] max_mag;
  logic [MAG_W-1:0] mag;
  logic             last;
  logic             capture;
  logic             gt;

  cplx_t bins_in [NBINS];
  cplx_t frame   [NBINS];

  assign bins_in[0]  = fft_d0;
  assign bins_in[1]  = fft_d1;
  assign bins_in[2]  = fft_d2;
  assign bins_in[3]  = fft_d3;
  assign bins_in[4]  = fft_d4;
  assign bins_in[5]  = fft_d5;
  assign bins_in[6]  = fft_d6;
  assign bins_in[7]  = fft_d7;
  assign bins_in[8]  = fft_d8;
  assign bins_in[9]  = fft_d9;
  assign bins_in[10] = fft_d10;
  assign bins_in[11] = fft_d11;
  assign bins_in[12] = fft_d12;
  assign bins_in[13] = fft_d13;
  assign bins_in[14] = fft_d14;
  assign bins_in[15] = fft_d15;

  // A new frame is accepted when idle or on the final scan cycle, which lets
  // frames arrive back-to-back every 16 cycles without a bubble.
  assign last    = (state == SCAN) && (idx == IDX_W'(NBINS - 1));
  assign capture = fft_valid && ((state == IDLE) || last);

  always_comb begin
    state_nxt = state;
    if (capture) begin
      state_nxt = SCAN;
    end else if (last) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame capture stage
  always_ff @(posedge clk) begin
    if (capture && !rst) begin
      for (int k = 0; k < NBINS; k++) begin
        frame[k] <= bins_in[k];
      end
    end
  end

  // Scan stage: one magnitude per cycle against the running maximum
  fas_mag_sq u_mag_sq (
    .sample (frame[idx]),
    .mag    (mag)
  );

  assign gt = (mag > max_mag);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      max_mag <= '0;
      max_idx <= '0;
      done    <= 1'b0;
      freq    <= '0;
      overrun <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        freq <= gt ? idx : max_idx;
      end

      if (capture) begin
        idx     <= '0;
        max_mag <= '0;
        max_idx <= '0;
      end else if (state == SCAN) begin
        idx <= idx + 1'b1;
        if (gt) begin
          max_mag <= mag;
          max_idx <= idx;
        end
      end

      if (fft_valid && (state == SCAN) && !last) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fas_freq_analyzer.sv
// Scoreboard bench for fas_freq_analyzer: directed frames from the test plan
// plus randomized frames, checked against an argmax-of-|X|^2 reference model.
module tb_fas_freq_analyzer;

  typedef struct {
    int f;
    int due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fft_valid = 1'b0;
  logic [31:0] d [16];
  logic        done;
  logic        overrun;
  logic [3:0]  freq;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   armed = 1'b0;
  int   model_freq = 0;
  bit   model_ovr = 1'b0;
  int   last_cap = -100;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fas_freq_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]),   .fft_d1(d[1]),   .fft_d2(d[2]),   .fft_d3(d[3]),
    .fft_d4(d[4]),   .fft_d5(d[5]),   .fft_d6(d[6]),   .fft_d7(d[7]),
    .fft_d8(d[8]),   .fft_d9(d[9]),   .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .done(done), .freq(freq), .overrun(overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: index of the strictly largest re^2+im^2, lowest index on ties.
  function automatic int peak_bin();
    longint best_m = -1;
    int     best = 0;
    for (int k = 0; k < 16; k++) begin
      logic signed [15:0] r16, i16;
      longint re, im, m;
      r16 = d[k][31:16];
      i16 = d[k][15:0];
      re = r16;
      im = i16;
      m = re * re + im * im;
      if (m > best_m) begin
        best_m = m;
        best = k;
      end
    end
    return best;
  endfunction

  task automatic model_capture(input int edge_n);
    if (edge_n < last_cap + 16) begin
      model_ovr = 1'b1;
    end else begin
      q.push_back('{peak_bin(), edge_n + 16});
      last_cap = edge_n;
    end
  endtask

  task automatic send();
    @(negedge clk);
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    model_capture(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    model_ovr = 1'b0;
    model_freq = 0;
    last_cap = -100;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 16; k++) d[k] = 32'h0;
  endtask

  // Monitor: pops the scoreboard whenever done is seen, checks holds otherwise.
  always @(negedge clk) begin
    if (armed) begin
      if (q.size() > 0 && cyc > q[0].due) begin
        e = q.pop_front();
        check("missing_done", 0, 1);
        model_freq = e.f;
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("freq", freq, e.f);
          check("done_latency", cyc, e.due);
          model_freq = e.f;
        end
      end else begin
        check("done_low", done, 0);
        check("freq_hold", freq, model_freq);
      end
      check("overrun", overrun, model_ovr);
    end
  end

  initial begin
    clear_frame();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_done", done, 0);
    check("reset_freq", freq, 0);
    check("reset_overrun", overrun, 0);
    armed = 1'b1;

    // single peak at bin 3
    clear_frame();
    d[3] = 32'h0100_0000;
    send();
    idle(20);
    check("single_peak", freq, 3);
    check("single_peak_ovr", overrun, 0);

    // sign and width corners
    clear_frame();
    d[0]  = 32'h7FFF_0000;
    d[5]  = 32'h8000_0000;
    d[12] = 32'h8000_8000;
    send();
    idle(20);
    check("sign_width", freq, 12);

    // tie keeps the lower index, then an all-zero frame
    clear_frame();
    d[2] = 32'h0040_FFC0;
    d[9] = 32'h0040_FFC0;
    send();
    idle(20);
    check("tie_low", freq, 2);
    clear_frame();
    send();
    idle(20);
    check("all_zero", freq, 0);

    // back-to-back frames 16 cycles apart
    clear_frame();
    d[7] = 32'h0200_0100;
    send();
    idle(15);
    clear_frame();
    d[14] = 32'hFE00_0300;
    send();
    idle(20);
    check("b2b_second", freq, 14);
    check("b2b_no_ovr", overrun, 0);

    // overrun: second frame 5 cycles after the first is dropped
    clear_frame();
    d[4] = 32'h0100_0100;
    send();
    idle(4);
    clear_frame();
    d[11] = 32'h7000_7000;
    send();
    idle(20);
    check("ovr_first_kept", freq, 4);
    check("ovr_sticky", overrun, 1);
    do_reset();
    check("ovr_cleared", overrun, 0);

    // reset mid-scan at idx = 8
    clear_frame();
    d[6] = 32'h0300_0000;
    send();
    idle(8);
    do_reset();
    idle(20);
    check("abort_freq", freq, 0);
    clear_frame();
    d[1] = 32'h0000_0500;
    send();
    idle(20);
    check("after_reset", freq, 1);

    // randomized frames and gaps
    for (int it = 0; it < 40; it++) begin
      int mode;
      int gap;
      mode = $urandom_range(0, 2);
      for (int k = 0; k < 16; k++) begin
        if (mode == 0) d[k] = $urandom;
        else if (mode == 1) d[k] = {16'($signed($urandom_range(0, 4)) - 2), 16'($signed($urandom_range(0, 4)) - 2)};
        else d[k] = 32'h0;
      end
      if (mode == 2) d[$urandom_range(0, 15)] = $urandom;
      gap = $urandom_range(1, 24);
      idle(gap - 1);
      send();
    end
    idle(24);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
